// File: rtl/wb_arbiter.sv
// Write-back arbiter for the single register-file write port.
// ALU results queue in an in-order FIFO; load results arrive on a
// valid/ready handshake and normally win, bounded by a starvation counter.
module wb_arbiter #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        rf_we,
  output logic [4:0]  rf_wr,
  output logic [31:0] rf_wd,
  output logic [31:0] pend_mask,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [4:0]    q_rd   [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [AW:0]   count;
  logic [SW-1:0] starve;

  logic          fifo_empty, fifo_full;
  logic          haz, force_alu;
  logic          alu_push, mem_take, alu_pop;
  logic [31:0]   fifo_mask;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(DEPTH));
  assign force_alu  = (starve == SW'(STARVE_MAX)) && !fifo_empty;

  assign alu_ready  = !fifo_full;
  assign mem_ready  = mem_valid && !haz && !force_alu;

  assign alu_push   = alu_valid && alu_ready;
  assign mem_take   = mem_valid && mem_ready;
  assign alu_pop    = !mem_take && !fifo_empty;

  assign busy       = !fifo_empty || rf_we;

  // Occupancy scan: pending-destination mask of valid entries and load hazard.
  always_comb begin
    logic [AW-1:0] off;
    fifo_mask = '0;
    haz       = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rptr;
      if ({1'b0, off} < count) begin
        fifo_mask = fifo_mask | (32'd1 << q_rd[i]);
        if (mem_rd != '0 && q_rd[i] == mem_rd)
          haz = 1'b1;
      end
    end
  end

  // Pending mask from state only; x0 never reported.
  always_comb begin
    pend_mask = fifo_mask;
    if (rf_we)
      pend_mask = pend_mask | (32'd1 << rf_wr);
    pend_mask[0] = 1'b0;
  end

  // FIFO storage, pointers, starvation counter and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_rd[i]   <= '0;
        q_data[i] <= '0;
      end
      rptr   <= '0;
      wptr   <= '0;
      count  <= '0;
      starve <= '0;
      rf_we  <= 1'b0;
      rf_wr  <= '0;
      rf_wd  <= '0;
    end else begin
      if (alu_push) begin
        q_rd[wptr]   <= alu_rd;
        q_data[wptr] <= alu_data;
        wptr         <= wptr + 1'b1;
      end
      if (alu_pop)
        rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(alu_push) - (AW+1)'(alu_pop);

      if (mem_take) begin
        rf_we <= (mem_rd != '0);
        rf_wr <= mem_rd;
        rf_wd <= mem_data;
      end else if (alu_pop) begin
        rf_we <= (q_rd[rptr] != '0);
        rf_wr <= q_rd[rptr];
        rf_wd <= q_data[rptr];
      end else begin
        rf_we <= 1'b0;
      end

      if (alu_pop || fifo_empty)
        starve <= '0;
      else if (mem_take && starve != SW'(STARVE_MAX))
        starve <= starve + 1'b1;
    end
  end

endmodule
